// File: rtl/memory_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and data load/store.
// Data has priority; a streak counter hands the port to a waiting fetch after MAX_STREAK data grants.
module memory_arbiter #(
    parameter int LATENCY    = 2,
    parameter int MAX_STREAK = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic        i_grant,
    output logic        i_valid,
    output logic [31:0] i_data,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    output logic        d_grant,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        stall_i,
    output logic        stall_d
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [CW-1:0] CNT_INIT   = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t         state_q;
    logic           owner_data_q;
    logic           write_q;
    logic [CW-1:0]  cnt_q;
    logic [SW-1:0]  streak_q;
    logic [31:0]    i_data_q;
    logic [31:0]    d_rdata_q;
    logic [31:0]    mem_address_q;
    logic [31:0]    mem_wdata_q;
    logic           mem_read_q;
    logic           mem_write_q;
    logic           i_valid_q;
    logic           d_valid_q;

    logic idle_ok;
    logic streak_full;
    logic gnt_instr;
    logic gnt_data;

    // Grants are combinational so the requester sees acceptance in the same cycle it asks.
    assign idle_ok     = (state_q == IDLE) && !reset;
    assign streak_full = (streak_q == STREAK_MAX);
    assign gnt_data    = idle_ok && d_req && (!i_req || !streak_full);
    assign gnt_instr   = idle_ok && i_req && (!d_req || streak_full);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_data_q  <= 1'b0;
            write_q       <= 1'b0;
            cnt_q         <= '0;
            streak_q      <= '0;
            i_data_q      <= '0;
            d_rdata_q     <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            i_valid_q     <= 1'b0;
            d_valid_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_data || gnt_instr) begin
                        owner_data_q  <= gnt_data;
                        write_q       <= gnt_data && d_write;
                        mem_address_q <= gnt_data ? d_address : i_address;
                        if (gnt_data) begin
                            mem_wdata_q <= d_wdata;
                        end
                        mem_read_q    <= !(gnt_data && d_write);
                        mem_write_q   <= gnt_data && d_write;
                        cnt_q         <= CNT_INIT;
                        state_q       <= ACCESS;
                        if (gnt_data && i_req) begin
                            streak_q <= streak_full ? streak_q : streak_q + 1'b1;
                        end else begin
                            streak_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // The write strobe is a single-cycle command; reads stay asserted throughout.
                    mem_write_q <= 1'b0;
                    if (cnt_q == '0) begin
                        mem_read_q <= 1'b0;
                        if (owner_data_q) begin
                            if (!write_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                        end else begin
                            i_data_q <= mem_rdata;
                        end
                        i_valid_q <= !owner_data_q;
                        d_valid_q <= owner_data_q;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    i_valid_q <= 1'b0;
                    d_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A reset landing on the completion cycle suppresses the pulse as well.
    assign i_valid     = i_valid_q && !reset;
    assign d_valid     = d_valid_q && !reset;
    assign i_grant     = gnt_instr;
    assign d_grant     = gnt_data;
    assign i_data      = i_data_q;
    assign d_rdata     = d_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign stall_i     = i_req && !i_valid;
    assign stall_d     = d_req && !d_valid;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter: a cycle-indexed transaction model checks every output each cycle,
// and directed sequences pin the model with hand-computed expectations.
module tb_memory_arbiter;

    localparam int L  = 2;
    localparam int MS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_write;
    logic [31:0] i_address, d_address, d_wdata, mem_rdata;
    logic        i_grant, i_valid, d_grant, d_valid;
    logic [31:0] i_data, d_rdata, mem_address, mem_wdata;
    logic        mem_read, mem_write, stall_i, stall_d;

    logic        r1_i_req;
    logic        r1_i_grant, r1_i_valid, r1_d_grant, r1_d_valid;
    logic [31:0] r1_i_data, r1_d_rdata, r1_mem_address, r1_mem_wdata;
    logic        r1_mem_read, r1_mem_write, r1_stall_i, r1_stall_d;

    always #5 clk = ~clk;

    memory_arbiter #(.LATENCY(L), .MAX_STREAK(MS)) u_dut (
        .clock(clk), .reset(reset),
        .i_req(i_req), .i_address(i_address), .i_grant(i_grant), .i_valid(i_valid), .i_data(i_data),
        .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .stall_i(stall_i), .stall_d(stall_d)
    );

    memory_arbiter #(.LATENCY(1), .MAX_STREAK(MS)) u_l1 (
        .clock(clk), .reset(reset),
        .i_req(r1_i_req), .i_address(32'h0000_0040), .i_grant(r1_i_grant), .i_valid(r1_i_valid),
        .i_data(r1_i_data),
        .d_req(1'b0), .d_write(1'b0), .d_address(32'h0), .d_wdata(32'h0),
        .d_grant(r1_d_grant), .d_valid(r1_d_valid), .d_rdata(r1_d_rdata),
        .mem_address(r1_mem_address), .mem_wdata(r1_mem_wdata), .mem_read(r1_mem_read),
        .mem_write(r1_mem_write), .mem_rdata(32'hCAFE_F00D), .stall_i(r1_stall_i), .stall_d(r1_stall_d)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Transaction model: one outstanding access, described by its grant cycle.
    bit          started = 0;
    bit          m_active = 0;
    int          m_t = 0;
    bit          m_owner_d = 0;
    bit          m_w = 0;
    int          m_streak = 0;
    logic [31:0] m_maddr = 0, m_wd = 0, m_idata = 0, m_drdata = 0;
    bit          last_gi = 0, last_gd = 0;

    always @(negedge clk) begin
        bit e_gi, e_gd, e_iv, e_dv, e_rd, e_wr;
        int rel;
        e_gi = 0; e_gd = 0; e_iv = 0; e_dv = 0; e_rd = 0; e_wr = 0;
        rel = cyc - m_t;
        if (m_active) begin
            if (rel >= 1 && rel <= L) begin
                e_rd = !m_w;
                e_wr = m_w && (rel == 1);
            end
            if (rel == L + 1) begin
                e_iv = !m_owner_d && !reset;
                e_dv = m_owner_d && !reset;
            end
        end else if (!reset) begin
            if (i_req && d_req) begin
                if (m_streak == MS) e_gi = 1;
                else                e_gd = 1;
            end else begin
                e_gi = i_req;
                e_gd = d_req;
            end
        end
        if (started) begin
            chk("i_grant", i_grant, e_gi);
            chk("d_grant", d_grant, e_gd);
            chk("i_valid", i_valid, e_iv);
            chk("d_valid", d_valid, e_dv);
            chk("mem_read", mem_read, e_rd);
            chk("mem_write", mem_write, e_wr);
            chk("mem_address", mem_address, m_maddr);
            chk("mem_wdata", mem_wdata, m_wd);
            chk("i_data", i_data, m_idata);
            chk("d_rdata", d_rdata, m_drdata);
            chk("stall_i", stall_i, i_req && !e_iv);
            chk("stall_d", stall_d, d_req && !e_dv);
        end
        last_gi = e_gi;
        last_gd = e_gd;
        if (reset) begin
            started  = 1;
            m_active = 0;
            m_streak = 0;
            m_maddr  = 0; m_wd = 0; m_idata = 0; m_drdata = 0;
        end else if (m_active) begin
            if (rel == L) begin
                if (!m_owner_d)  m_idata  = mem_rdata;
                else if (!m_w)   m_drdata = mem_rdata;
            end
            if (rel == L + 1) m_active = 0;
        end else if (e_gi || e_gd) begin
            m_active  = 1;
            m_t       = cyc;
            m_owner_d = e_gd;
            m_w       = e_gd && d_write;
            m_maddr   = e_gd ? d_address : i_address;
            if (e_gd) m_wd = d_wdata;
            if (e_gd && i_req) m_streak = (m_streak < MS) ? m_streak + 1 : MS;
            else               m_streak = 0;
        end
        cyc++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; i_req = 0; d_req = 0; d_write = 0; r1_i_req = 0;
        i_address = 0; d_address = 0; d_wdata = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        nxt();

        // Instruction load, LATENCY=2
        i_req = 1; i_address = 32'h10; mem_rdata = 32'hDEADBEEF;
        @(negedge clk); chk("t1_grant", i_grant, 1); chk("t1_stall_T", stall_i, 1);
        nxt(); @(negedge clk); chk("t1_rd_T1", mem_read, 1); chk("t1_addr", mem_address, 32'h10);
        chk("t1_stall_T1", stall_i, 1);
        nxt(); @(negedge clk); chk("t1_rd_T2", mem_read, 1); chk("t1_stall_T2", stall_i, 1);
        nxt(); @(negedge clk); chk("t1_valid", i_valid, 1); chk("t1_data", i_data, 32'hDEADBEEF);
        chk("t1_rd_T3", mem_read, 0); chk("t1_stall_T3", stall_i, 0);
        $display("txn I load addr=10 data=%h", i_data);

        // Store
        nxt();
        i_req = 0; d_req = 1; d_write = 1; d_address = 32'h80; d_wdata = 32'h1234;
        @(negedge clk); chk("t2_grant", d_grant, 1);
        nxt(); @(negedge clk); chk("t2_wr_T1", mem_write, 1); chk("t2_addr", mem_address, 32'h80);
        chk("t2_wdata", mem_wdata, 32'h1234); chk("t2_rd_T1", mem_read, 0);
        nxt(); @(negedge clk); chk("t2_wr_T2", mem_write, 0); chk("t2_rd_T2", mem_read, 0);
        nxt(); @(negedge clk); chk("t2_valid", d_valid, 1); chk("t2_rdata", d_rdata, 0);
        $display("txn D store addr=80 wdata=1234");

        // Both requesting loads continuously
        nxt();
        d_write = 0; d_address = 32'h200; i_address = 32'h300; i_req = 1; d_req = 1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("t3_igrant", i_grant, (k % 4 == 0) && ((k / 4) % 4 == 3));
            chk("t3_dgrant", d_grant, (k % 4 == 0) && ((k / 4) % 4 != 3));
            if (k % 4 == 0) $display("txn contended grant k=%0d owner=%s", k, i_grant ? "I" : "D");
            nxt();
        end
        i_req = 0; d_req = 0;
        nxt();

        // Back-to-back data only
        d_req = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t4_dgrant", d_grant, (k % 4 == 0));
            if (k % 4 == 0) $display("txn D back-to-back k=%0d", k);
            nxt();
        end
        d_req = 0;
        nxt();

        // Reset during the second access cycle of a load
        d_req = 1; d_address = 32'h44; mem_rdata = 32'h5555AAAA;
        @(negedge clk); chk("t5_grant", d_grant, 1);
        nxt(); d_req = 0;
        nxt(); reset = 1;
        @(negedge clk); chk("t5_dvalid_rst", d_valid, 0);
        nxt(); reset = 0; d_req = 1;
        @(negedge clk); chk("t5_dvalid", d_valid, 0); chk("t5_rd", mem_read, 0);
        chk("t5_addr", mem_address, 0); chk("t5_rdata", d_rdata, 0); chk("t5_idata", i_data, 0);
        chk("t5_regrant", d_grant, 1);
        $display("txn D load aborted by reset, regrant=%0d", d_grant);
        nxt(); d_req = 0;
        repeat (4) nxt();

        // LATENCY=1 instance
        r1_i_req = 1;
        @(negedge clk); chk("l1_grant", r1_i_grant, 1);
        nxt(); r1_i_req = 0;
        @(negedge clk); chk("l1_rd_T1", r1_mem_read, 1); chk("l1_valid_T1", r1_i_valid, 0);
        nxt();
        @(negedge clk); chk("l1_rd_T2", r1_mem_read, 0); chk("l1_valid_T2", r1_i_valid, 1);
        chk("l1_data", r1_i_data, 32'hCAFEF00D);
        $display("txn L1 I load data=%h", r1_i_data);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            nxt();
            mem_rdata = $urandom;
            reset = ($urandom_range(0, 199) == 0);
            if (i_req && !last_gi) begin
                if ($urandom_range(0, 15) == 0) i_req = 0;
            end else begin
                i_req = ($urandom_range(0, 3) != 0);
                i_address = $urandom;
            end
            if (d_req && !last_gd) begin
                if ($urandom_range(0, 15) == 0) d_req = 0;
            end else begin
                d_req = ($urandom_range(0, 3) != 0);
                d_write = $urandom_range(0, 1);
                d_address = $urandom;
                d_wdata = $urandom;
            end
            if (last_gi) $display("txn rand I grant cyc=%0d addr=%h", cyc - 1, mem_address);
            if (last_gd) $display("txn rand D grant cyc=%0d addr=%h", cyc - 1, mem_address);
        end
        nxt();
        reset = 0; i_req = 0; d_req = 0;
        repeat (6) nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
